rr_index_encoder: RTL and testbench
===================================

Name: rr_index_encoder

Overview:
Registered, handshaked successor to the combinational one-hot/priority-to-integer encoder. It accepts a request vector and returns the binary index of the selected bit, plus flags for no-request and multiple-request cases. Two modes: fixed priority (highest set index wins) and round-robin (rotating pointer, starvation-free). It sits between request-vector producers (issue/writeback/unit-select logic) and consumers that need an integer ID under backpressure.

Parameters:
C_WIDTH, 32, request vector width; any value >= 1, not restricted to powers of two.
C_ROUND_ROBIN, 0, 0 = fixed priority (highest set index wins); 1 = round-robin.
INDEX_W (localparam), ($clog2(C_WIDTH) > 0) ? $clog2(C_WIDTH) : 1, index width.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset; synchronous, active-high.
in_req  input  C_WIDTH  request vector; any number of bits may be set.
in_valid  input  1  in_req is valid.
in_ready  output  1  block can accept in_req this cycle.
out_index  output  INDEX_W  selected bit index.
out_one_hot  output  C_WIDTH  one-hot vector of the selected bit; all zero when out_none = 1.
out_none  output  1  the accepted in_req was all zero.
out_multiple  output  1  the accepted in_req had two or more bits set.
out_valid  output  1  output register holds a result.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst = 1 at an edge): out_valid = 0, out_index = 0, out_one_hot = 0, out_none = 0, out_multiple = 0, rr pointer = 0. Reset overrides any handshake in the same cycle. A result in flight is discarded and never presented.
- Single-entry output register. in_ready = !out_valid || out_ready (combinational; no path from in_req or in_valid to in_ready).
- Input accept = in_valid && in_ready.
  - On an accept edge, all output fields load and out_valid = 1.
  - Latency: exactly 1 cycle, accept edge to out_valid visible.
- Output handshake = out_valid && out_ready.
  - On a handshake with no accept in the same cycle, out_valid goes to 0 and the data fields hold their last values.
  - Simultaneous handshake and accept: the register reloads and out_valid stays 1. Full throughput is one result per cycle.
- While out_valid = 1 && out_ready = 0, all output fields hold stable.
- Fixed mode (C_ROUND_ROBIN = 0):
  - The winner is the highest set index.
  - The pointer is unused and constant 0.
- Round-robin mode (C_ROUND_ROBIN = 1):
  - Search starts at pointer p, goes upward and wraps from C_WIDTH-1 to 0. The first set bit wins.
  - On an accept with in_req != 0, p <= (winner == C_WIDTH-1) ? 0 : winner+1. The wrap must be correct for non-power-of-two C_WIDTH.
  - The pointer updates at accept time, not output-handshake time, so back-to-back accepts use the updated pointer.
- in_req == 0 on accept: out_none = 1, out_index = 0, out_one_hot = 0, out_multiple = 0, pointer unchanged.
- out_multiple = 1 when popcount(in_req) >= 2. It is independent of mode.
- in_req and in_valid are ignored when no accept occurs; the pointer does not move.
- C_WIDTH = 1:
  - out_index is always 0.
  - out_none = !in_req[0].
  - out_multiple is always 0.
- Assertions: out_one_hot is zero or one-hot. When out_none = 0, out_one_hot[out_index] = 1.

Test Plan:
1. Fixed mode, C_WIDTH = 8, in_req = 8'b1000_0101, out_ready = 1 -> one cycle later out_valid = 1, out_index = 7, out_one_hot = 8'h80, out_multiple = 1, out_none = 0.
2. RR mode, C_WIDTH = 8, after reset, in_req = 8'b1000_0101 held valid 4 cycles, out_ready = 1 -> out_index sequence 0, 2, 7, 0 on consecutive cycles, no bubbles.
3. Backpressure: RR mode, out_ready = 0 after the first result, in_valid held -> in_ready = 0, out_index frozen, pointer frozen. Raise out_ready -> in_ready = 1 in the same cycle, next result appears on the following cycle.
4. Zero request: RR mode with pointer = 3, accept in_req = 0 -> out_none = 1, out_index = 0, out_one_hot = 0. Next accept of 8'b0000_1001 -> out_index = 3.
5. Non-power-of-two: RR mode, C_WIDTH = 5, in_req = 5'b10001 accepted 3 times -> out_index 0, 4, 0 (pointer wraps 4 -> 0); INDEX_W = 3.
6. Reset mid-operation: out_valid = 1, out_ready = 0, pointer = 5, assert rst for one cycle -> out_valid = 0 next cycle. Next accept of 8'hFF -> out_index = 0.

Source files
------------

// File: rtl/rr_index_encoder.sv
// Purpose : request vector -> binary index of the selected bit (fixed-priority or round-robin), plus none/multiple flags.
// Latency : 1 cycle from input accept to out_valid; one result per cycle sustained.
// Backpr. : single-entry output register; in_ready = !out_valid || out_ready, results hold while out_ready is low.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_req/in_valid/in_ready      request vector with valid/ready handshake
//   out_index/out_one_hot         selected bit as binary index and one-hot vector
//   out_none/out_multiple         accepted vector had zero / two-or-more bits set
//   out_valid/out_ready           result handshake
module rr_index_encoder #(
  parameter  int C_WIDTH       = 32,
  parameter  int C_ROUND_ROBIN = 0,
  localparam int INDEX_W       = ($clog2(C_WIDTH) > 0) ? $clog2(C_WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [C_WIDTH-1:0] in_req,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [C_WIDTH-1:0] out_one_hot,
  output logic               out_none,
  output logic               out_multiple,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [INDEX_W-1:0] win_idx;
  logic [C_WIDTH-1:0] win_oh;
  logic               found;
  logic               multiple;
  logic               accept;
  logic               handshake;
  int                 rr_pos;

  logic               valid_q, valid_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [C_WIDTH-1:0] oh_q, oh_d;
  logic               none_q, none_d;
  logic               mult_q, mult_d;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = valid_q && out_ready;

  // Winner selection. In round-robin mode the scan starts at the pointer and
  // wraps explicitly at C_WIDTH, so non-power-of-two widths work.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    rr_pos  = 0;
    if (C_ROUND_ROBIN != 0) begin
      for (int i = 0; i < C_WIDTH; i++) begin
        rr_pos = int'(ptr_q) + i;
        if (rr_pos >= C_WIDTH) rr_pos = rr_pos - C_WIDTH;
        if (!found && in_req[rr_pos]) begin
          found   = 1'b1;
          win_idx = INDEX_W'(rr_pos);
        end
      end
    end else begin
      // Ascending scan, last hit kept: highest set index wins.
      for (int i = 0; i < C_WIDTH; i++) begin
        if (in_req[i]) begin
          found   = 1'b1;
          win_idx = INDEX_W'(i);
        end
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < C_WIDTH; i++) begin
      win_oh[i] = found && (win_idx == INDEX_W'(i));
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multiple = |(in_req & (in_req - C_WIDTH'(1)));

  // Pointer moves at accept time so back-to-back accepts see the new value.
  always_comb begin
    ptr_d = ptr_q;
    if (C_ROUND_ROBIN == 0) begin
      ptr_d = '0;
    end else if (accept && found) begin
      ptr_d = (win_idx == INDEX_W'(C_WIDTH - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    index_d = index_q;
    oh_d    = oh_q;
    none_d  = none_q;
    mult_d  = mult_q;
    if (accept) begin
      valid_d = 1'b1;
      index_d = win_idx;
      oh_d    = win_oh;
      none_d  = !found;
      mult_d  = multiple;
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      oh_q    <= '0;
      none_q  <= 1'b0;
      mult_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      index_q <= index_d;
      oh_q    <= oh_d;
      none_q  <= none_d;
      mult_q  <= mult_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_index    = index_q;
  assign out_one_hot  = oh_q;
  assign out_none     = none_q;
  assign out_multiple = mult_q;

  // Output invariants: one-hot is zero or one-hot, and agrees with the index.
  always_ff @(posedge clk) begin
    if (!rst && valid_q) begin
      assert ((oh_q & (oh_q - C_WIDTH'(1))) == '0);
      if (!none_q) begin
        assert (oh_q[index_q]);
      end
    end
  end

endmodule

// File: tb/tb_rr_index_encoder.sv
module tb_rr_index_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] req_a  [3];
  logic        vld_a  [3];
  logic        ordy_a [3];

  logic       rdy0, rdy1, rdy2;
  logic [2:0] idx0, idx1, idx2;
  logic [7:0] oh0, oh1;
  logic [4:0] oh2;
  logic       none0, none1, none2;
  logic       mult0, mult1, mult2;
  logic       ov0, ov1, ov2;

  // 0: fixed priority W=8, 1: round-robin W=8, 2: round-robin W=5
  rr_index_encoder #(.C_WIDTH(8), .C_ROUND_ROBIN(0)) u0 (
    .clk(clk), .rst(rst), .in_req(req_a[0][7:0]), .in_valid(vld_a[0]), .in_ready(rdy0),
    .out_index(idx0), .out_one_hot(oh0), .out_none(none0), .out_multiple(mult0),
    .out_valid(ov0), .out_ready(ordy_a[0]));
  rr_index_encoder #(.C_WIDTH(8), .C_ROUND_ROBIN(1)) u1 (
    .clk(clk), .rst(rst), .in_req(req_a[1][7:0]), .in_valid(vld_a[1]), .in_ready(rdy1),
    .out_index(idx1), .out_one_hot(oh1), .out_none(none1), .out_multiple(mult1),
    .out_valid(ov1), .out_ready(ordy_a[1]));
  rr_index_encoder #(.C_WIDTH(5), .C_ROUND_ROBIN(1)) u2 (
    .clk(clk), .rst(rst), .in_req(req_a[2][4:0]), .in_valid(vld_a[2]), .in_ready(rdy2),
    .out_index(idx2), .out_one_hot(oh2), .out_none(none2), .out_multiple(mult2),
    .out_valid(ov2), .out_ready(ordy_a[2]));

  int W  [3] = '{8, 8, 5};
  bit RR [3] = '{1'b0, 1'b1, 1'b1};

  // Reference model: output register contents and round-robin pointer.
  int          m_ptr   [3];
  bit          m_valid [3];
  int          m_idx   [3];
  logic [31:0] m_oh    [3];
  bit          m_none  [3];
  bit          m_mult  [3];

  int checks = 0;
  int passes = 0;

  logic [31:0] o_idx, o_oh;
  logic        o_none, o_mult, o_ov, o_rdy;

  function automatic void check(string tag, logic [31:0] obs_v, logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
  endfunction

  function automatic logic [31:0] width_mask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Winner by the selection rules: highest set bit, or first set bit at
  // positions p, p+1, ... taken modulo the width.
  function automatic int ref_winner(logic [31:0] r, int w, bit rr, int p);
    if (r == 32'd0) return -1;
    if (!rr) begin
      for (int i = w - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < w; k++) if (r[(p + k) % w]) return (p + k) % w;
    end
    return -1;
  endfunction

  task automatic obs(input int n);
    case (n)
      0: begin o_idx = 32'(idx0); o_oh = 32'(oh0); o_none = none0; o_mult = mult0; o_ov = ov0; o_rdy = rdy0; end
      1: begin o_idx = 32'(idx1); o_oh = 32'(oh1); o_none = none1; o_mult = mult1; o_ov = ov1; o_rdy = rdy1; end
      default: begin o_idx = 32'(idx2); o_oh = 32'(oh2); o_none = none2; o_mult = mult2; o_ov = ov2; o_rdy = rdy2; end
    endcase
  endtask

  task automatic model_clear(input int n);
    m_ptr[n] = 0; m_valid[n] = 1'b0; m_idx[n] = 0; m_oh[n] = 32'd0;
    m_none[n] = 1'b0; m_mult[n] = 1'b0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check all
  // outputs 1 time unit after the edge. Callers drive inputs after return.
  task automatic cycle();
    logic [31:0] r;
    bit          acc;
    int          win;
    #1;
    for (int n = 0; n < 3; n++) begin
      obs(n);
      check($sformatf("in_ready[%0d]", n), 32'(o_rdy), 32'(!m_valid[n] || ordy_a[n]));
      if (rst) begin
        model_clear(n);
      end else begin
        r   = req_a[n] & width_mask(W[n]);
        acc = vld_a[n] && (!m_valid[n] || ordy_a[n]);
        if (acc) begin
          win         = ref_winner(r, W[n], RR[n], m_ptr[n]);
          m_valid[n]  = 1'b1;
          m_none[n]   = (r == 32'd0);
          m_idx[n]    = (win < 0) ? 0 : win;
          m_oh[n]     = (win < 0) ? 32'd0 : (32'd1 << win);
          m_mult[n]   = ($countones(r) >= 2);
          if (RR[n] && win >= 0) m_ptr[n] = (win + 1) % W[n];
        end else if (m_valid[n] && ordy_a[n]) begin
          m_valid[n] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      obs(n);
      check($sformatf("out_valid[%0d]", n),    32'(o_ov),   32'(m_valid[n]));
      check($sformatf("out_index[%0d]", n),    o_idx,       32'(m_idx[n]));
      check($sformatf("out_one_hot[%0d]", n),  o_oh,        m_oh[n]);
      check($sformatf("out_none[%0d]", n),     32'(o_none), 32'(m_none[n]));
      check($sformatf("out_multiple[%0d]", n), 32'(o_mult), 32'(m_mult[n]));
    end
  endtask

  initial begin
    int exp_rr8 [4];
    int exp_rr5 [3];
    logic [31:0] r;
    exp_rr8 = '{0, 2, 7, 0};
    exp_rr5 = '{0, 4, 0};

    for (int n = 0; n < 3; n++) begin
      req_a[n] = 32'd0; vld_a[n] = 1'b0; ordy_a[n] = 1'b1;
      model_clear(n);
    end

    // Reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      obs(n);
      check("rst_valid", 32'(o_ov), 32'd0);
      check("rst_onehot", o_oh, 32'd0);
    end

    // Fixed priority: highest set index wins
    req_a[0] = 32'h85; vld_a[0] = 1'b1;
    cycle();
    vld_a[0] = 1'b0;
    obs(0);
    check("t1_valid", 32'(o_ov), 32'd1);
    check("t1_index", o_idx, 32'd7);
    check("t1_onehot", o_oh, 32'h80);
    check("t1_multiple", 32'(o_mult), 32'd1);
    check("t1_none", 32'(o_none), 32'd0);

    // Round-robin back-to-back, no bubbles
    req_a[1] = 32'h85; vld_a[1] = 1'b1; ordy_a[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      obs(1);
      check($sformatf("t2_index%0d", k), o_idx, 32'(exp_rr8[k]));
      check($sformatf("t2_valid%0d", k), 32'(o_ov), 32'd1);
    end

    // Backpressure: output and pointer frozen
    ordy_a[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      obs(1);
      check("t3_in_ready_low", 32'(o_rdy), 32'd0);
      check("t3_index_frozen", o_idx, 32'd0);
    end
    ordy_a[1] = 1'b1;
    #1;
    obs(1);
    check("t3_in_ready_same_cycle", 32'(o_rdy), 32'd1);
    cycle();
    obs(1);
    check("t3_next_index", o_idx, 32'd2);
    vld_a[1] = 1'b0;
    cycle();

    // Zero request with pointer at 3
    req_a[1] = 32'h00; vld_a[1] = 1'b1;
    cycle();
    obs(1);
    check("t4_none", 32'(o_none), 32'd1);
    check("t4_index", o_idx, 32'd0);
    check("t4_onehot", o_oh, 32'd0);
    req_a[1] = 32'h09;
    cycle();
    obs(1);
    check("t4_index_after_zero", o_idx, 32'd3);
    vld_a[1] = 1'b0;
    cycle();

    // Non-power-of-two width wrap
    req_a[2] = 32'h11; vld_a[2] = 1'b1; ordy_a[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      obs(2);
      check($sformatf("t5_index%0d", k), o_idx, 32'(exp_rr5[k]));
    end
    vld_a[2] = 1'b0;

    // Reset mid-operation with pointer at 5
    req_a[1] = 32'h10; vld_a[1] = 1'b1;
    cycle();
    obs(1);
    check("t6_index4", o_idx, 32'd4);
    ordy_a[1] = 1'b0; req_a[1] = 32'hFF;
    cycle();
    obs(1);
    check("t6_held_valid", 32'(o_ov), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    obs(1);
    check("t6_valid_after_rst", 32'(o_ov), 32'd0);
    cycle();
    obs(1);
    check("t6_index_after_rst", o_idx, 32'd0);
    check("t6_multiple_after_rst", 32'(o_mult), 32'd1);
    vld_a[1] = 1'b0; ordy_a[1] = 1'b1;
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 3; n++) begin
        vld_a[n]  = ($urandom_range(0, 3) != 0);
        ordy_a[n] = ($urandom_range(0, 3) != 0);
        r = $urandom;
        case ($urandom_range(0, 3))
          0: r = 32'd0;
          1: r = 32'd1 << $urandom_range(0, W[n] - 1);
          2: r = r & $urandom;
          default: ;
        endcase
        req_a[n] = r;
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    for (int n = 0; n < 3; n++) vld_a[n] = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
